// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned DWIDTH   = 32;
  localparam int unsigned WORDSIZE = DWIDTH / 8;
  localparam logic [DWIDTH-1:0] ZERO     = '0;
  localparam logic [31:0]       NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    IF_BUSY,
    LSU_BUSY
  } arb_state_t;

endpackage

// File: rtl/arb_watchdog.sv
// Counts stalled cycles of an outstanding memory access and flags the abort cycle.
module arb_watchdog #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic busy,
  input  logic ack,
  output logic expire
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // The edge that would make the count reach TIMEOUT is the abort edge; ack on it wins.
  assign expire = busy & ~ack & (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!busy || ack) begin
      cnt <= '0;
    end else if (cnt != CW'(TIMEOUT)) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and the LSU.
// Optional ARB_PERF_EN adds grant and wait-cycle performance counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW         = DWIDTH,
  parameter int unsigned DW         = DWIDTH,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic [DW-1:0]   if_rdata,
  output logic            if_valid,
  input  logic            lsu_req,
  input  logic            lsu_we,
  input  logic [AW-1:0]   lsu_addr,
  input  logic [DW-1:0]   lsu_wdata,
  input  logic [DW/8-1:0] lsu_be,
  output logic [DW-1:0]   lsu_rdata,
  output logic            lsu_done,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_ack,
  input  logic [DW-1:0]   mem_rdata,
  output logic            fetch_stall,
  output logic            lsu_stall,
  output logic            err
`ifdef ARB_PERF_EN
  ,
  output logic [31:0]     perf_if_grants,
  output logic [31:0]     perf_lsu_grants,
  output logic [31:0]     perf_wait_cycles
`endif
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  arb_state_t    state;
  logic [SW-1:0] starve_cnt;
  logic          lsu_grant_c;
  logic          if_grant_c;
  logic          expire;

  assign fetch_stall = if_req & ~if_valid;
  assign lsu_stall   = lsu_req & ~lsu_done;

  // LSU wins unless fetch has been passed over STARVE_MAX times in a row.
  assign lsu_grant_c = (state == IDLE) & lsu_req & (starve_cnt < SW'(STARVE_MAX));
  assign if_grant_c  = (state == IDLE) & ~lsu_grant_c & if_req;

  arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .busy   (state != IDLE),
    .ack    (mem_ack),
    .expire (expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      if_rdata   <= '0;
      if_valid   <= 1'b0;
      lsu_rdata  <= '0;
      lsu_done   <= 1'b0;
      err        <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      lsu_done <= 1'b0;
      err      <= 1'b0;
      case (state)
        IDLE: begin
          if (lsu_grant_c) begin
            state      <= LSU_BUSY;
            mem_req    <= 1'b1;
            mem_we     <= lsu_we;
            mem_addr   <= lsu_addr;
            mem_wdata  <= lsu_wdata;
            mem_be     <= lsu_be;
            // Grant condition keeps the count below STARVE_MAX, so +1 saturates there.
            starve_cnt <= if_req ? starve_cnt + SW'(1) : '0;
          end else if (if_grant_c) begin
            state      <= IF_BUSY;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            mem_wdata  <= '0;
            mem_be     <= '1;
            starve_cnt <= '0;
          end else begin
            starve_cnt <= '0;
          end
        end
        IF_BUSY: begin
          if (mem_ack) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            if_rdata <= mem_rdata;
            if_valid <= 1'b1;
          end else if (expire) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            if_rdata <= DW'(NOP_INSN);
            if_valid <= 1'b1;
            err      <= 1'b1;
          end
        end
        LSU_BUSY: begin
          if (mem_ack) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            lsu_done <= 1'b1;
            if (!mem_we) begin
              lsu_rdata <= mem_rdata;
            end
          end else if (expire) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            lsu_rdata <= DW'(ZERO);
            lsu_done  <= 1'b1;
            err       <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARB_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_if_grants   <= '0;
      perf_lsu_grants  <= '0;
      perf_wait_cycles <= '0;
    end else begin
      if (if_grant_c) begin
        perf_if_grants <= perf_if_grants + 32'd1;
      end
      if (lsu_grant_c) begin
        perf_lsu_grants <= perf_lsu_grants + 32'd1;
      end
      if (fetch_stall | lsu_stall) begin
        perf_wait_cycles <= perf_wait_cycles + 32'd1;
      end
    end
  end
`endif

endmodule
